// File: rtl/capture_rdseq_pkg.sv
// capture_rdseq_pkg: register offsets, control/status bit positions and FSM states
// shared by capture_read_sequencer and its bench-visible register map.
package capture_rdseq_pkg;
   localparam logic [2:0] REG_CTRL   = 3'd0;
   localparam logic [2:0] REG_BASE   = 3'd1;
   localparam logic [2:0] REG_COUNT  = 3'd2;
   localparam logic [2:0] REG_STATUS = 3'd3;
   localparam logic [2:0] REG_DATA   = 3'd4;
   localparam logic [2:0] REG_WRAP   = 3'd5;
   localparam int CTRL_START  = 0;
   localparam int CTRL_ABORT  = 1;
   localparam int CTRL_IRQ_EN = 2;
   localparam int STAT_BUSY = 0;
   localparam int STAT_DONE = 1;
   localparam int STAT_UNF  = 2;
   localparam int STAT_LVL  = 4;
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
endpackage

// File: rtl/rdseq_fifo.sv
// rdseq_fifo: synchronous DATA_W x DEPTH readout FIFO with flush and fill level.
module rdseq_fifo #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   input  logic [DATA_W-1:0]        wdata_i,
   output logic [DATA_W-1:0]        rdata_o,
   output logic [$clog2(DEPTH):0]   level_o,
   output logic                     empty_o
);
   localparam int PW = $clog2(DEPTH);
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
   logic [PW:0] lvl_q, lvl_d;
   always_comb begin
      wp_d  = flush_i ? '0 : wp_q + PW'(push_i);
      rp_d  = flush_i ? '0 : rp_q + PW'(pop_i);
      lvl_d = flush_i ? '0 : lvl_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         wp_q  <= '0;
         rp_q  <= '0;
         lvl_q <= '0;
      end else begin
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         lvl_q <= lvl_d;
      end
   always_ff @(posedge clk)
      if (push_i && !flush_i) mem_q[wp_q] <= wdata_i;
   assign rdata_o = mem_q[rp_q];
   assign level_o = lvl_q;
   assign empty_o = lvl_q == '0;
endmodule

// File: rtl/capture_read_sequencer.sv
// capture_read_sequencer: Avalon-MM self-timed burst reader from sample RAM into a readout FIFO.
// Define CAPTURE_RDSEQ_WRAP_EN to add the WRAP register for circular capture buffers.
module capture_read_sequencer
   import capture_rdseq_pkg::*;
#(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 16,
   parameter int FIFO_DEPTH  = 4,
   parameter int RAM_LATENCY = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [2:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic              read_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_rd,
   input  logic [DATA_W-1:0] ram_rddata,
   output logic              irq
);
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
   state_t state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d, addr_q, addr_d, addr_nxt;
   logic [15:0] count_q, count_d, rem_q, rem_d;
   logic irq_en_q, irq_en_d, done_q, done_d, unf_q, unf_d;
   logic [RAM_LATENCY-1:0] infl_q, infl_d;
   logic wr, rd, start, abort, busy, issue, pop, flush, empty;
   logic [LVL_W-1:0] level;
   logic [31:0] infl_cnt, wrap_rd;
   logic [DATA_W-1:0] head;
   logic unused_wdata;
   assign wr    = chipselect && !write_n;
   assign rd    = chipselect && !read_n;
   assign busy  = state_q != IDLE;
   assign start = wr && address == REG_CTRL && writedata[CTRL_START];
   assign abort = wr && address == REG_CTRL && writedata[CTRL_ABORT] && busy;
   assign pop   = rd && address == REG_DATA && !empty;
   assign infl_cnt = $countones(infl_q);
   // Credit: every issued word already owns a FIFO slot, so the FIFO cannot overflow.
   assign issue = state_q == ISSUE && !abort && (32'(level) + infl_cnt < 32'(FIFO_DEPTH));
   assign unused_wdata = ^writedata[31:16];
`ifdef CAPTURE_RDSEQ_WRAP_EN
   logic [ADDR_W-1:0] wrap_q, wrap_d;
   assign wrap_d   = (wr && address == REG_WRAP) ? writedata[ADDR_W-1:0] : wrap_q;
   assign addr_nxt = (addr_q == wrap_q) ? '0 : addr_q + ADDR_W'(1);
   assign wrap_rd  = 32'(wrap_q);
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) wrap_q <= '1;
      else wrap_q <= wrap_d;
`else
   assign addr_nxt = addr_q + ADDR_W'(1);
   assign wrap_rd  = '0;
`endif
   always_comb begin
      state_d  = state_q;
      base_d   = (wr && address == REG_BASE) ? writedata[ADDR_W-1:0] : base_q;
      count_d  = (wr && address == REG_COUNT) ? writedata[15:0] : count_q;
      irq_en_d = (wr && address == REG_CTRL) ? writedata[CTRL_IRQ_EN] : irq_en_q;
      done_d   = (wr && address == REG_STATUS && writedata[STAT_DONE]) ? 1'b0 : done_q;
      unf_d    = (wr && address == REG_STATUS && writedata[STAT_UNF]) ? 1'b0 : unf_q;
      addr_d   = issue ? addr_nxt : addr_q;
      rem_d    = issue ? rem_q - 16'd1 : rem_q;
      infl_d   = RAM_LATENCY'({infl_q, issue});
      flush    = 1'b0;
      if (rd && address == REG_DATA && empty) unf_d = 1'b1;
      unique case (state_q)
         IDLE:
            if (start && count_q == '0) done_d = 1'b1;
            else if (start) begin
               state_d = ISSUE;
               addr_d  = base_q;
               rem_d   = count_q;
               flush   = 1'b1;
            end
         ISSUE: if (issue && rem_q == 16'd1) state_d = DRAIN;
         DRAIN:
            if (infl_q == '0 && !abort) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         default: state_d = IDLE;
      endcase
      // Abort drops queued and returning samples by clearing the in-flight valids.
      if (abort) begin
         state_d = IDLE;
         flush   = 1'b1;
         infl_d  = '0;
      end
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state_q  <= IDLE;
         base_q   <= '0;
         count_q  <= '0;
         irq_en_q <= 1'b0;
         done_q   <= 1'b0;
         unf_q    <= 1'b0;
         addr_q   <= '0;
         rem_q    <= '0;
         infl_q   <= '0;
      end else begin
         state_q  <= state_d;
         base_q   <= base_d;
         count_q  <= count_d;
         irq_en_q <= irq_en_d;
         done_q   <= done_d;
         unf_q    <= unf_d;
         addr_q   <= addr_d;
         rem_q    <= rem_d;
         infl_q   <= infl_d;
      end
   rdseq_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push_i  (infl_q[RAM_LATENCY-1]),
      .pop_i   (pop),
      .flush_i (flush),
      .wdata_i (ram_rddata),
      .rdata_o (head),
      .level_o (level),
      .empty_o (empty)
   );
   assign readdata =
      !rd                    ? '0 :
      address == REG_CTRL   ? (32'(irq_en_q) << CTRL_IRQ_EN) | (32'(busy) << STAT_BUSY) :
      address == REG_BASE   ? 32'(base_q) :
      address == REG_COUNT  ? 32'(count_q) :
      address == REG_STATUS ? (32'(level) << STAT_LVL) | (32'(unf_q) << STAT_UNF) |
                              (32'(done_q) << STAT_DONE) | (32'(busy) << STAT_BUSY) :
      address == REG_DATA   ? (empty ? '0 : 32'(head)) :
      address == REG_WRAP   ? wrap_rd : '0;
   assign ram_addr = addr_q;
   assign ram_rd   = issue;
   assign irq      = done_q & irq_en_q;
endmodule

// File: tb/tb_capture_read_sequencer.sv
// tb_capture_read_sequencer: register table, directed burst/abort/reset sequences and
// randomized bursts checked against an address-list / FIFO-order model.
module tb_capture_read_sequencer;
   localparam int ADDR_W = 16, DATA_W = 16, FIFO_DEPTH = 4, RAM_LATENCY = 2;
`ifdef CAPTURE_RDSEQ_WRAP_EN
   localparam logic [31:0] WRAP_RST = 32'hFFFF, WRAP_RB = 32'h55;
`else
   localparam logic [31:0] WRAP_RST = 32'h0, WRAP_RB = 32'h0;
`endif
   typedef struct {
      string       name;
      logic        wr;
      logic [2:0]  a;
      logic [31:0] d;
      logic [31:0] exp;
   } vec_t;
   logic clk = 0, reset_n = 0, chipselect = 0, write_n = 1, read_n = 1, ram_rd, irq;
   logic [2:0] address = 0;
   logic [31:0] writedata = 0, readdata, r;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_rddata;
   logic [ADDR_W-1:0] rp [RAM_LATENCY];
   logic [ADDR_W-1:0] iss_a[$];
   int iss_c[$];
   logic [DATA_W-1:0] exp_q[$];
   vec_t vq[$];
   int cyc = 0, n_chk = 0, n_err = 0, i0, n, got, budget, bad, c;
   logic [15:0] b;
   logic ie;

   capture_read_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH),
                            .RAM_LATENCY(RAM_LATENCY)) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(readdata),
      .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_rddata(ram_rddata), .irq(irq));

   always #5 clk = ~clk;

   function automatic logic [DATA_W-1:0] exp_data(input logic [ADDR_W-1:0] a);
      return DATA_W'(a + 16'h1000);
   endfunction

   // Sample RAM: data for the address presented with ram_rd appears RAM_LATENCY cycles later.
   always @(posedge clk) begin
      rp[0] <= ram_addr;
      for (int k = 1; k < RAM_LATENCY; k++) rp[k] <= rp[k-1];
   end
   assign ram_rddata = exp_data(rp[RAM_LATENCY-1]);

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (ram_rd) begin
         iss_a.push_back(ram_addr);
         iss_c.push_back(cyc);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick(input int k);
      repeat (k) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      chipselect = 1; write_n = 0; address = a; writedata = d;
      tick(1);
      chipselect = 0; write_n = 1;
   endtask

   task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
      chipselect = 1; read_n = 0; address = a;
      #1 d = readdata;
      @(posedge clk);
      #1 chipselect = 0; read_n = 1;
   endtask

   task automatic wait_idle();
      logic [31:0] s;
      int k;
      k = 0;
      bus_read(3'd3, s);
      while (s[0] && k < 200) begin
         bus_read(3'd3, s);
         k++;
      end
      chk("idle reached", 32'(s[0]), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tick(3);
      chk("reset ram_rd", 32'(ram_rd), 0);
      chk("reset ram_addr", 32'(ram_addr), 0);
      chk("reset irq", 32'(irq), 0);
      chk("reset readdata", readdata, 0);
      reset_n = 1;
      tick(2);
      // Register table
      vq.push_back('{"ctrl rst",    1'b0, 3'd0, 32'h0,        32'h0});
      vq.push_back('{"status rst",  1'b0, 3'd3, 32'h0,        32'h0});
      vq.push_back('{"base rst",    1'b0, 3'd1, 32'h0,        32'h0});
      vq.push_back('{"count rst",   1'b0, 3'd2, 32'h0,        32'h0});
      vq.push_back('{"wrap rst",    1'b0, 3'd5, 32'h0,        WRAP_RST});
      vq.push_back('{"base rw",     1'b1, 3'd1, 32'hFFFF1234, 32'h1234});
      vq.push_back('{"count rw",    1'b1, 3'd2, 32'h000ABCDE, 32'hBCDE});
      vq.push_back('{"ctrl irq_en", 1'b1, 3'd0, 32'h4,        32'h4});
      vq.push_back('{"ctrl clr",    1'b1, 3'd0, 32'h0,        32'h0});
      vq.push_back('{"reg6 ignore", 1'b1, 3'd6, 32'hDEAD,     32'h0});
      vq.push_back('{"base kept",   1'b0, 3'd1, 32'h0,        32'h1234});
      vq.push_back('{"reg7 zero",   1'b0, 3'd7, 32'h0,        32'h0});
      vq.push_back('{"wrap rw",     1'b1, 3'd5, 32'h55,       WRAP_RB});
      for (int i = 0; i < vq.size(); i++) begin
         if (vq[i].wr) bus_write(vq[i].a, vq[i].d);
         bus_read(vq[i].a, r);
         chk(vq[i].name, r, vq[i].exp);
      end
`ifdef CAPTURE_RDSEQ_WRAP_EN
      bus_write(3'd5, 32'hFFFF);
`endif
      // Basic 3-word burst with interrupt
      i0 = iss_a.size();
      bus_write(3'd1, 32'h100);
      bus_write(3'd2, 32'd3);
      bus_write(3'd0, 32'h5);
      chk("first ram_rd", 32'(ram_rd), 1);
      chk("first ram_addr", 32'(ram_addr), 32'h100);
      n = 0;
      while (!irq && n < 50) begin
         tick(1);
         n++;
      end
      chk("done latency", n, 1 + 2 + RAM_LATENCY + 1);
      bus_read(3'd3, r);
      chk("status after burst", r, 32'h32);
      bus_read(3'd0, r);
      chk("ctrl after burst", r, 32'h4);
      chk("burst issues", iss_a.size() - i0, 3);
      if (iss_a.size() - i0 == 3)
         for (int k = 0; k < 3; k++) begin
            chk("burst addr", 32'(iss_a[i0+k]), 32'h100 + k);
            chk("burst consecutive", iss_c[i0+k] - iss_c[i0], k);
         end
      for (int k = 0; k < 3; k++) begin
         bus_read(3'd4, r);
         chk("burst data", r, 32'h1100 + k);
      end
      chk("irq set", 32'(irq), 1);
      // Underflow
      bus_read(3'd4, r);
      chk("empty data", r, 0);
      bus_read(3'd3, r);
      chk("underflow set", r, 32'h06);
      bus_write(3'd3, 32'h4);
      bus_read(3'd3, r);
      chk("underflow clr", r, 32'h02);
      bus_write(3'd3, 32'h2);
      chk("irq clr", 32'(irq), 0);
      // Credit stall with 10 words and no reads
      bus_write(3'd1, 32'h200);
      bus_write(3'd2, 32'd10);
      i0 = iss_a.size();
      bus_write(3'd0, 32'h1);
      tick(30);
      chk("stall issues", iss_a.size() - i0, FIFO_DEPTH);
      bus_read(3'd3, r);
      chk("stall status", r, 32'h41);
      for (int i = 0; i < 10; i++) begin
         bus_read(3'd4, r);
         chk("stall data", r, 32'(exp_data(16'h200 + 16'(i))));
         tick(6);
         chk("issue per pop", iss_a.size() - i0, (5 + i < 10) ? 5 + i : 10);
      end
      bus_read(3'd3, r);
      chk("stall done", r, 32'h02);
      bus_write(3'd3, 32'h2);
      // Abort two cycles after START
      bus_write(3'd1, 32'h300);
      bus_write(3'd2, 32'd8);
      bus_write(3'd0, 32'h1);
      tick(1);
      bus_write(3'd0, 32'h2);
      chk("abort ram_rd", 32'(ram_rd), 0);
      bus_read(3'd3, r);
      chk("abort status", r, 0);
      tick(5);
      bus_read(3'd3, r);
      chk("abort late drop", r, 0);
      bus_read(3'd4, r);
      chk("abort data", r, 0);
      bus_read(3'd3, r);
      chk("abort underflow", r, 32'h04);
      bus_write(3'd3, 32'h4);
      // START with COUNT = 0
      bus_write(3'd2, 32'd0);
      i0 = iss_a.size();
      bus_write(3'd0, 32'h1);
      chk("zero ram_rd", 32'(ram_rd), 0);
      bus_read(3'd3, r);
      chk("zero done", r, 32'h02);
      tick(3);
      chk("zero issues", iss_a.size() - i0, 0);
      bus_write(3'd3, 32'h2);
`ifdef CAPTURE_RDSEQ_WRAP_EN
      bus_write(3'd5, 32'hFF);
      bus_write(3'd1, 32'hFE);
      bus_write(3'd2, 32'd4);
      i0 = iss_a.size();
      bus_write(3'd0, 32'h1);
      wait_idle();
      chk("wrap issues", iss_a.size() - i0, 4);
      for (int k = 0; k < 4; k++) begin
         b = 16'hFE + 16'(k);
         if (b == 16'h100) b = 16'h0;
         if (b == 16'h101) b = 16'h1;
         if (iss_a.size() > i0 + k) chk("wrap addr", 32'(iss_a[i0+k]), 32'(b));
         bus_read(3'd4, r);
         chk("wrap data", r, 32'(exp_data(b)));
      end
      bus_write(3'd3, 32'h2);
`endif
      // Asynchronous reset mid-burst
      bus_write(3'd1, 32'h400);
      bus_write(3'd2, 32'd8);
      bus_write(3'd0, 32'h5);
      tick(2);
      reset_n = 0;
      #1;
      chk("rst ram_rd", 32'(ram_rd), 0);
      chk("rst ram_addr", 32'(ram_addr), 0);
      chk("rst irq", 32'(irq), 0);
      bus_read(3'd3, r);
      chk("rst readdata", r, 0);
      reset_n = 1;
      bus_read(3'd3, r);
      chk("rst status", r, 0);
      bus_read(3'd0, r);
      chk("rst ctrl", r, 0);
      tick(5);
      bus_read(3'd3, r);
      chk("rst no done", r, 0);
      // Randomized bursts against the address-list / FIFO-order model
      for (int it = 0; it < 15; it++) begin
         b  = 16'($urandom);
         c  = $urandom_range(1, 12);
         ie = 1'($urandom_range(0, 1));
         bus_write(3'd3, 32'h6);
         bus_write(3'd1, 32'(b));
         bus_write(3'd2, 32'(c));
         exp_q.delete();
         for (int k = 0; k < c; k++) exp_q.push_back(exp_data(b + 16'(k)));
         i0 = iss_a.size();
         bus_write(3'd0, {29'b0, ie, 2'b01});
         got = 0;
         budget = 300;
         while (got < c && budget > 0) begin
            tick($urandom_range(0, 3));
            bus_read(3'd3, r);
            if (r[7:4] != 0) begin
               bus_read(3'd4, r);
               chk("rand data", r, 32'(exp_q[got]));
               got++;
            end
            budget--;
         end
         chk("rand count", got, c);
         wait_idle();
         chk("rand issues", iss_a.size() - i0, c);
         bad = 0;
         for (int k = 0; k < c; k++)
            if (iss_a.size() > i0 + k && iss_a[i0+k] !== b + 16'(k)) bad++;
         chk("rand addrs", bad, 0);
         chk("rand irq", 32'(irq), 32'(ie));
         bus_read(3'd3, r);
         chk("rand status", r, 32'h02);
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
